mux4_sel_seq: RTL and testbench



---
 rtl/mux4_sel_seq.sv | 151 +++++++++++++++
 tb/tb_mux4_sel_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_sel_seq.sv
// Select sequencer for a 4:1 mux: steps s1/s0 through channels a..d.
// Optional channel-mask feature enabled with `define MUX_SEQ_MASK_EN.
module mux4_sel_seq #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [DWELL_W-1:0] dwell,
`ifdef MUX_SEQ_MASK_EN
   input  logic [3:0]         ch_mask,
`endif
   output logic               s1,
   output logic               s0,
   output logic               busy,
   output logic               sample,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [3:0]         mask_q;
   logic [3:0]         start_mask;

`ifdef MUX_SEQ_MASK_EN
   logic [3:0] mask_d;
   assign start_mask = ch_mask;
`else
   assign mask_q     = 4'hF;
   assign start_mask = 4'hF;
`endif

   // Lowest enabled channel; only meaningful when m is non-zero.
   function automatic logic [1:0] first_idx(input logic [3:0] m);
      first_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) first_idx = 2'(i);
      end
   endfunction

   // {found, idx} of the lowest enabled channel above cur.
   function automatic logic [2:0] next_idx(input logic [3:0] m,
                                           input logic [1:0] cur);
      next_idx = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) next_idx = {1'b1, 2'(i)};
      end
   endfunction

   logic [2:0] nxt;
   assign nxt = next_idx(mask_q, sel_q);

   // Next-state and datapath decision for the scan FSM.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef MUX_SEQ_MASK_EN
      mask_d  = mask_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
`ifdef MUX_SEQ_MASK_EN
               mask_d = ch_mask;
`endif
               if (|start_mask) begin
                  state_d = RUN;
                  sel_d   = first_idx(start_mask);
                  cnt_d   = dwell;
                  dwell_d = dwell;
                  busy_d  = 1'b1;
               end else begin
                  // Nothing to visit: finish immediately.
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q == '0) begin
               if (nxt[2]) begin
                  sel_d = nxt[1:0];
                  cnt_d = dwell_q;
               end else if (continuous) begin
                  sel_d = first_idx(mask_q);
                  cnt_d = dwell_q;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any scan without done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         cnt_q   <= '0;
         dwell_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MUX_SEQ_MASK_EN
         mask_q  <= 4'h0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MUX_SEQ_MASK_EN
         mask_q  <= mask_d;
`endif
      end
   end

   assign s1     = sel_q[1];
   assign s0     = sel_q[0];
   assign busy   = busy_q;
   assign done   = done_q;
   assign sample = (state_q == RUN) && (cnt_q == '0);

endmodule

// File: tb/tb_mux4_sel_seq.sv
// Self-checking bench for mux4_sel_seq against a per-scan trace model.
// Build with +define+MUX_SEQ_MASK_EN to exercise the channel mask.
module tb_mux4_sel_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       continuous;
   logic [7:0] dwell;
`ifdef MUX_SEQ_MASK_EN
   logic [3:0] ch_mask;
`endif
   logic       s1, s0, busy, sample, done;

   int n_checks;
   int n_fail;
   logic [1:0] hold_sel;
   // Expected per-cycle {sel[1:0], busy, sample, done}.
   logic [4:0] exp_q[$];

   mux4_sel_seq #(.DWELL_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .continuous(continuous),
      .dwell(dwell),
`ifdef MUX_SEQ_MASK_EN
      .ch_mask(ch_mask),
`endif
      .s1(s1),
      .s0(s0),
      .busy(busy),
      .sample(sample),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Trace model: each enabled channel held d+1 cycles, sample on
   // the last, then optionally one idle cycle with done.
   function automatic void build(input int d, input logic [3:0] m,
                                 input int scans, input bit with_done);
      logic [1:0] last;
      last = hold_sel;
      for (int s = 0; s < scans; s++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
               last = 2'(ch);
               for (int k = 0; k <= d; k++)
                  exp_q.push_back({2'(ch), 1'b1, (k == d), 1'b0});
            end
         end
      end
      if (with_done) exp_q.push_back({last, 3'b001});
   endfunction

   function automatic logic [1:0] top_ch(input logic [3:0] m);
      top_ch = hold_sel;
      for (int ch = 0; ch < 4; ch++) if (m[ch]) top_ch = 2'(ch);
   endfunction

   function automatic logic [3:0] eff_mask(input logic [3:0] m);
`ifdef MUX_SEQ_MASK_EN
      eff_mask = m;
`else
      eff_mask = 4'hF;
`endif
   endfunction

   task automatic do_start(input int d, input logic [3:0] m,
                           input bit cont);
      dwell      = d[7:0];
      continuous = cont;
`ifdef MUX_SEQ_MASK_EN
      ch_mask    = m;
`endif
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      obs = {s1, s0, busy, sample, done};
      n_checks++;
      if (obs !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_hold: got %b want 00000", obs);
      end
      rst = 1'b0;
      @(negedge clk);
      obs = {s1, s0, busy, sample, done};
      n_checks++;
      if (obs !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 00000", obs);
      end
      hold_sel = 2'd0;
   endtask

   // One single-shot scan; optionally pulses start while busy and
   // changes dwell after the scan was accepted.
   task automatic run_single(input string nm, input int d,
                             input logic [3:0] m, input bit pulse,
                             input bit chg);
      logic [4:0] obs;
      logic [3:0] em;
      em = eff_mask(m);
      exp_q.delete();
      build(d, em, 1, 1'b1);
      do_start(d, m, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = {s1, s0, busy, sample, done};
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b want %b", nm, i, obs, exp_q[i]);
         end
         if (chg && i == 1) dwell = 8'd5;
         start = pulse && exp_q[i][2] && (i % 3 == 1);
         @(negedge clk);
      end
      start = 1'b0;
      if (|em) hold_sel = top_ch(em);
      obs = {s1, s0, busy, sample, done};
      n_checks++;
      if (obs !== {hold_sel, 3'b000}) begin
         n_fail++;
         $display("FAIL %s_idle: got %b want %b", nm, obs, {hold_sel, 3'b000});
      end
   endtask

   task automatic test_single();
      run_single("single_d0", 0, 4'hF, 1'b0, 1'b0);
      run_single("single_d2", 2, 4'hF, 1'b0, 1'b1);
      run_single("busy_start", 1, 4'hF, 1'b1, 1'b0);
   endtask

   task automatic test_continuous();
      logic [4:0] obs;
      exp_q.delete();
      build(1, 4'hF, 3, 1'b0);
      do_start(1, 4'hF, 1'b1);
      for (int i = 0; i <= 20; i++) begin
         obs = {s1, s0, busy, sample, done};
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_fail++;
            $display("FAIL cont[%0d]: got %b want %b", i, obs, exp_q[i]);
         end
         if (i == 20) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      continuous = 1'b0;
      for (int i = 0; i < 2; i++) begin
         obs = {s1, s0, busy, sample, done};
         n_checks++;
         if (obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL cont_stop[%0d]: got %b want 10000", i, obs);
         end
         @(negedge clk);
      end
      hold_sel = 2'd2;
   endtask

   task automatic test_start_stop_idle();
      logic [4:0] obs;
      start = 1'b1;
      stop  = 1'b1;
      dwell = 8'd0;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         obs = {s1, s0, busy, sample, done};
         n_checks++;
         if (obs !== {hold_sel, 3'b000}) begin
            n_fail++;
            $display("FAIL start_stop[%0d]: got %b want %b", i, obs,
                     {hold_sel, 3'b000});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rst_mid();
      logic [4:0] obs;
      do_start(3, 4'hF, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         obs = {s1, s0, busy, sample, done};
         n_checks++;
         if (obs !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid[%0d]: got %b want 00000", i, obs);
         end
         @(negedge clk);
      end
      hold_sel = 2'd0;
   endtask

   task automatic test_boundary();
      run_single("dwell_max", 255, 4'hF, 1'b0, 1'b0);
   endtask

   task automatic test_mask();
`ifdef MUX_SEQ_MASK_EN
      run_single("mask_1010", 0, 4'b1010, 1'b0, 1'b0);
      run_single("mask_0", 0, 4'b0000, 1'b0, 1'b0);
      run_single("mask_0100", 1, 4'b0100, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_random();
      int d;
      logic [3:0] m;
      for (int n = 0; n < 8; n++) begin
         d = $urandom_range(0, 6);
         m = 4'($urandom_range(0, 15));
         run_single("rand", d, m, ($urandom_range(0, 1) == 1), 1'b1);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      hold_sel   = 2'd0;
      rst        = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      continuous = 1'b0;
      dwell      = 8'd0;
`ifdef MUX_SEQ_MASK_EN
      ch_mask    = 4'hF;
`endif
      test_reset();
      test_single();
      test_continuous();
      test_start_stop_idle();
      test_rst_mid();
      test_boundary();
      test_mask();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
